// File: rtl/vga_sync_decoder.sv
// Receive side of the VGA timing interface: measures hsync/vsync timing, locks to the
// configured mode and recovers pixel coordinates plus an active-video qualifier.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic        active_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        err_o,
    output logic [10:0] h_len_o,
    output logic [10:0] v_len_o
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned GOOD_W  = 4;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  H_TOTAL_C = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0]  V_TOTAL_C = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0]  H_START_C = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0]  H_END_C   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_START_C = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0]  V_END_C   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic                frame_bad_q, frame_bad_d;
    logic                err_d;

    logic                hs_s1, hs_s2;
    logic                vs_s1;
    logic                vs_at_edge;
    logic [CNT_W-1:0]    hcnt, vcnt;
    logic [CNT_W-1:0]    hcnt_inc, vcnt_inc;

    logic                h_edge;
    logic                boundary;
    logic                line_good;
    logic                frame_len_ok;
    logic                frame_good;
    logic                hsync_lost;
    logic                h_in_win, v_in_win;
    logic                active_d;

    // Edge and measurement qualifiers, all from registered (synchronised) samples.
    assign h_edge       = hs_s1 & ~hs_s2;
    assign boundary     = h_edge & vs_s1 & ~vs_at_edge;
    assign hcnt_inc     = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + CNT_W'(1);
    assign vcnt_inc     = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + CNT_W'(1);
    assign line_good    = (hcnt_inc == H_TOTAL_C);
    assign frame_len_ok = (vcnt_inc == V_TOTAL_C);
    assign frame_good   = ~frame_bad_q & line_good & frame_len_ok;
    assign hsync_lost   = (hcnt == H_TOTAL_C);

    assign h_in_win = (hcnt >= H_START_C) && (hcnt < H_END_C);
    assign v_in_win = (vcnt >= V_START_C) && (vcnt < V_END_C);
    assign active_d = (state_d == LOCKED) && h_in_win && v_in_win;

    // Lock state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= SEARCH;
            good_cnt_q  <= '0;
            frame_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    // Lock next-state logic; an error in LOCKED takes priority over a boundary.
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        frame_bad_d = frame_bad_q;
        err_d       = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (boundary) begin
                    state_d     = MEASURE;
                    good_cnt_d  = '0;
                    frame_bad_d = 1'b0;
                end
            end
            MEASURE: begin
                if (boundary) begin
                    frame_bad_d = 1'b0;
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        if (good_cnt_d >= LOCK_GOOD) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (h_edge && !line_good) begin
                    frame_bad_d = 1'b1;
                end
            end
            LOCKED: begin
                if ((h_edge && !line_good) || (boundary && !frame_len_ok) || hsync_lost) begin
                    state_d     = SEARCH;
                    good_cnt_d  = '0;
                    frame_bad_d = 1'b0;
                    err_d       = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Input synchronisers, line/frame counters, measurements and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hs_s1         <= 1'b0;
            hs_s2         <= 1'b0;
            vs_s1         <= 1'b0;
            vs_at_edge    <= 1'b0;
            hcnt          <= '0;
            vcnt          <= '0;
            h_len_o       <= '0;
            v_len_o       <= '0;
            frame_start_o <= 1'b0;
            locked_o      <= 1'b0;
            err_o         <= 1'b0;
            active_o      <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
        end else begin
            hs_s1 <= (hsync_i == SYNC_POL);
            hs_s2 <= hs_s1;
            vs_s1 <= (vsync_i == SYNC_POL);

            if (h_edge) begin
                hcnt       <= '0;
                h_len_o    <= hcnt_inc;
                vs_at_edge <= vs_s1;
                if (boundary) begin
                    vcnt    <= '0;
                    v_len_o <= vcnt_inc;
                end else begin
                    vcnt <= vcnt_inc;
                end
            end else begin
                hcnt <= hcnt_inc;
            end

            frame_start_o <= boundary;
            err_o         <= err_d;
            locked_o      <= (state_d == LOCKED);
            active_o      <= active_d;
            x_o           <= active_d ? COORD_W'(hcnt - H_START_C) : '0;
            y_o           <= active_d ? COORD_W'(vcnt - V_START_C) : '0;
        end
    end

endmodule
